glay_axi_read_arbiter: RTL and testbench

Round-robin arbiter that shares the kernel's single AXI4 read master port among NUM_REQUESTERS engines (PEs/caches) inside the GLay CU. It accepts AR requests from each requester and tags each accepted request with the requester index in ARID. It returns R beats to the owner by decoding RID, and caps outstanding bursts per requester. It sits between the CU's per-engine read ports and the read-channel registers of the kernel AFU.

---
 rtl/glay_axi_read_arbiter_pkg.sv | 17 +
 rtl/glay_axi_read_arbiter_if.sv | 46 ++++
 rtl/glay_rr_priority_encoder.sv | 30 +++
 rtl/glay_axi_read_arbiter.sv | 178 +++++++++++++++++
 tb/tb_glay_axi_read_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/glay_axi_read_arbiter_pkg.sv
// Shared types and defaults for the GLay AXI read arbiter.
package glay_axi_read_arbiter_pkg;

    localparam int CU_COUNT_LOCAL                  = 4;
    localparam int M_AXI_MEMORY_ADDR_WIDTH         = 64;
    localparam int M_AXI_MEMORY_DATA_WIDTH_BITS    = 512;
    localparam int CACHE_AXI_ID_W                  = 4;
    localparam int ARBITER_MAX_OUTSTANDING_DEFAULT = 8;

    typedef enum logic {ARB_IDLE, ARB_ISSUE} axi_read_arbiter_state_t;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/glay_axi_read_arbiter_if.sv
// Requester-side and master-side AXI read signals of the arbiter.
interface glay_axi_read_arbiter_if #(
    parameter int NUM_REQUESTERS = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 512,
    parameter int ID_WIDTH       = 4
);
    logic [NUM_REQUESTERS-1:0]            req_arvalid;
    logic [NUM_REQUESTERS-1:0]            req_arready;
    logic [NUM_REQUESTERS*ADDR_WIDTH-1:0] req_araddr;
    logic [NUM_REQUESTERS*8-1:0]          req_arlen;
    logic [NUM_REQUESTERS-1:0]            req_rvalid;
    logic [NUM_REQUESTERS-1:0]            req_rready;
    logic [DATA_WIDTH-1:0]                req_rdata;
    logic                                 req_rlast;
    logic [1:0]                           req_rresp;

    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [ID_WIDTH-1:0]   m_axi_arid;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [ID_WIDTH-1:0]   m_axi_rid;
    logic                  m_axi_rlast;
    logic [1:0]            m_axi_rresp;

    // Arbiter view: serves the requesters, masters the AXI port.
    modport master (
        input  req_arvalid, req_araddr, req_arlen, req_rready,
        input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rid, m_axi_rlast, m_axi_rresp,
        output req_arready, req_rvalid, req_rdata, req_rlast, req_rresp,
        output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arid, m_axi_rready
    );

    // Environment view: requesters plus the memory side.
    modport slave (
        output req_arvalid, req_araddr, req_arlen, req_rready,
        output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rid, m_axi_rlast, m_axi_rresp,
        input  req_arready, req_rvalid, req_rdata, req_rlast, req_rresp,
        input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arid, m_axi_rready
    );

endinterface

// File: rtl/glay_rr_priority_encoder.sv
// Combinational round-robin pick: first eligible index after last_grant, wrapping.
module glay_rr_priority_encoder
    import glay_axi_read_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]            eligible,
    input  logic [idx_width(N)-1:0] last_grant,
    output logic                    grant_valid,
    output logic [idx_width(N)-1:0] grant
);
    localparam int IDX_W = idx_width(N);

    // Scan offsets 1..N from last_grant; the first hit wins.
    always_comb begin
        int  idx;
        logic hit;
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        hit         = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx         = (int'(last_grant) + k) % N;
            hit         = eligible[idx] && !grant_valid;
            grant       = hit ? IDX_W'(idx) : grant;
            grant_valid = grant_valid | hit;
        end
    end

endmodule

// File: rtl/glay_axi_read_arbiter.sv
// Round-robin AR arbiter with RID-based R routing and per-requester burst caps.
// Optional stall counter port enabled by GLAY_AXI_READ_ARBITER_PERF_EN.
module glay_axi_read_arbiter
    import glay_axi_read_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS  = CU_COUNT_LOCAL,
    parameter int ADDR_WIDTH      = M_AXI_MEMORY_ADDR_WIDTH,
    parameter int DATA_WIDTH      = M_AXI_MEMORY_DATA_WIDTH_BITS,
    parameter int ID_WIDTH        = CACHE_AXI_ID_W,
    parameter int MAX_OUTSTANDING = ARBITER_MAX_OUTSTANDING_DEFAULT
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    glay_axi_read_arbiter_if.master bus,
    output logic                    busy,
    output logic                    rid_error
`ifdef GLAY_AXI_READ_ARBITER_PERF_EN
    ,
    output logic [31:0]             perf_ar_stall_cycles
`endif
);
    localparam int                       IDX_W   = idx_width(NUM_REQUESTERS);
    localparam int                       CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]         CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [NUM_REQUESTERS-1:0] ONE_HOT0 = NUM_REQUESTERS'(1);

    axi_read_arbiter_state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [7:0]              arlen_q, arlen_d;
    logic [ID_WIDTH-1:0]     arid_q, arid_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [CNT_W-1:0]        outst_q [NUM_REQUESTERS];
    logic [CNT_W-1:0]        outst_d [NUM_REQUESTERS];
    logic                    rid_error_q, rid_error_d;

    logic [NUM_REQUESTERS-1:0] eligible_s, rvalid_s, r_done_s, inc_s, dec_s, underflow_s, nonzero_s;
    logic                      grant_valid_s, accept_s, rid_in_range_s, rready_sel_s;
    logic [IDX_W-1:0]          grant_idx_s;

    // Per-requester eligibility, RID decode and counter events.
    always_comb begin
        eligible_s   = '0;
        rvalid_s     = '0;
        r_done_s     = '0;
        inc_s        = '0;
        dec_s        = '0;
        underflow_s  = '0;
        nonzero_s    = '0;
        rready_sel_s = 1'b0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            nonzero_s[k]   = (outst_q[k] != '0);
            eligible_s[k]  = bus.req_arvalid[k] && (outst_q[k] < CNT_MAX);
            rvalid_s[k]    = bus.m_axi_rvalid && (bus.m_axi_rid == ID_WIDTH'(k));
            rready_sel_s   = rready_sel_s | ((bus.m_axi_rid == ID_WIDTH'(k)) && bus.req_rready[k]);
            r_done_s[k]    = rvalid_s[k] && bus.req_rready[k] && bus.m_axi_rlast;
            inc_s[k]       = accept_s && (grant_idx_s == IDX_W'(k));
            dec_s[k]       = r_done_s[k] && nonzero_s[k];
            underflow_s[k] = r_done_s[k] && !nonzero_s[k];
        end
    end

    glay_rr_priority_encoder #(.N(NUM_REQUESTERS)) u_rr (
        .eligible    (eligible_s),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid_s),
        .grant       (grant_idx_s)
    );

    assign accept_s       = grant_valid_s && ((state_q == ARB_IDLE) || bus.m_axi_arready);
    assign rid_in_range_s = ({1'b0, bus.m_axi_rid} < (ID_WIDTH + 1)'(NUM_REQUESTERS));

    assign bus.req_arready   = accept_s ? (ONE_HOT0 << grant_idx_s) : '0;
    assign bus.req_rvalid    = rvalid_s;
    assign bus.req_rdata     = bus.m_axi_rdata;
    assign bus.req_rlast     = bus.m_axi_rlast;
    assign bus.req_rresp     = bus.m_axi_rresp;
    // Beats for unknown IDs are drained so the memory side never locks up.
    assign bus.m_axi_rready  = rid_in_range_s ? rready_sel_s : 1'b1;
    assign bus.m_axi_arvalid = (state_q == ARB_ISSUE);
    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arlen   = arlen_q;
    assign bus.m_axi_arid    = arid_q;
    assign busy              = (state_q == ARB_ISSUE) || (|nonzero_s);
    assign rid_error         = rid_error_q;

    // AR stage next state and output register loading.
    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arid_d       = arid_q;
        last_grant_d = last_grant_q;
        if (accept_s) begin
            araddr_d     = bus.req_araddr[grant_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
            arlen_d      = bus.req_arlen[grant_idx_s*8 +: 8];
            arid_d       = ID_WIDTH'(grant_idx_s);
            last_grant_d = grant_idx_s;
        end else begin
            last_grant_d = last_grant_q;
        end
        case (state_q)
            ARB_IDLE: begin
                if (accept_s) begin
                    state_d = ARB_ISSUE;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                if (accept_s) begin
                    state_d = ARB_ISSUE;
                end else if (bus.m_axi_arready) begin
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_ISSUE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Outstanding counters: simultaneous accept and completion cancel out.
    always_comb begin
        rid_error_d = rid_error_q | (bus.m_axi_rvalid && !rid_in_range_s) | (|underflow_s);
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            if (inc_s[k] && !dec_s[k]) begin
                outst_d[k] = outst_q[k] + CNT_W'(1);
            end else if (dec_s[k] && !inc_s[k]) begin
                outst_d[k] = outst_q[k] - CNT_W'(1);
            end else begin
                outst_d[k] = outst_q[k];
            end
        end
    end

    // State, AR output register, grant pointer, counters and error flag.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= ARB_IDLE;
            araddr_q     <= '0;
            arlen_q      <= 8'd0;
            arid_q       <= '0;
            last_grant_q <= IDX_W'(NUM_REQUESTERS - 1);
            rid_error_q  <= 1'b0;
            for (int k = 0; k < NUM_REQUESTERS; k++) begin
                outst_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arid_q       <= arid_d;
            last_grant_q <= last_grant_d;
            rid_error_q  <= rid_error_d;
            for (int k = 0; k < NUM_REQUESTERS; k++) begin
                outst_q[k] <= outst_d[k];
            end
        end
    end

`ifdef GLAY_AXI_READ_ARBITER_PERF_EN
    logic [31:0] perf_q;

    // Saturating count of cycles where the AR beat is offered but not taken.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            perf_q <= 32'd0;
        end else if ((state_q == ARB_ISSUE) && !bus.m_axi_arready && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end else begin
            perf_q <= perf_q;
        end
    end

    assign perf_ar_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_glay_axi_read_arbiter.sv
// Directed self-checking bench: 4 requesters, 32-bit address/data, cap of 2 bursts.
module tb_glay_axi_read_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic ap_clk = 1'b0;
    logic ap_rst_n;
    logic busy;
    logic rid_error;
`ifdef GLAY_AXI_READ_ARBITER_PERF_EN
    logic [31:0] perf_ar_stall_cycles;
`endif
    int checks   = 0;
    int failures = 0;

    glay_axi_read_arbiter_if #(.NUM_REQUESTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    glay_axi_read_arbiter #(
        .NUM_REQUESTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(2)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .bus       (bus),
        .busy      (busy),
        .rid_error (rid_error)
`ifdef GLAY_AXI_READ_ARBITER_PERF_EN
        ,
        .perf_ar_stall_cycles (perf_ar_stall_cycles)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.req_arvalid   = 4'b0000;
        bus.req_araddr    = '0;
        bus.req_arlen     = '0;
        bus.req_rready    = 4'b0000;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rid     = 4'd0;
        bus.m_axi_rlast   = 1'b0;
        bus.m_axi_rresp   = 2'b00;
    endtask

    task automatic do_reset;
        clear_inputs();
        ap_rst_n = 1'b0;
        tick();
        tick();
        ap_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        clear_inputs();
        ap_rst_n = 1'b0;
        tick();
        checks++; if (bus.m_axi_arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%0b exp=0", bus.m_axi_arvalid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (rid_error !== 1'b0) begin failures++; $display("FAIL reset_rid_error got=%0b exp=0", rid_error); end
        checks++; if (bus.m_axi_arid !== 4'd0 || bus.m_axi_araddr !== 32'd0) begin failures++; $display("FAIL reset_ar_regs arid=%0h araddr=%0h exp=0/0", bus.m_axi_arid, bus.m_axi_araddr); end
        tick();
        ap_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_request;
        do_reset();
        bus.req_arvalid           = 4'b0100;
        bus.req_araddr[2*AW +: AW] = 32'h0000_1000;
        bus.req_arlen[2*8 +: 8]    = 8'd3;
        bus.m_axi_arready         = 1'b1;
        #4;
        checks++; if (bus.req_arready !== 4'b0100) begin failures++; $display("FAIL single_arready got=%b exp=0100", bus.req_arready); end
        tick();
        bus.req_arvalid = 4'b0000;
        checks++; if (bus.m_axi_arvalid !== 1'b1 || bus.m_axi_arid !== 4'd2) begin failures++; $display("FAIL single_ar_out arvalid=%0b arid=%0d exp=1/2", bus.m_axi_arvalid, bus.m_axi_arid); end
        checks++; if (bus.m_axi_araddr !== 32'h1000 || bus.m_axi_arlen !== 8'd3) begin failures++; $display("FAIL single_ar_payload araddr=%0h arlen=%0d exp=1000/3", bus.m_axi_araddr, bus.m_axi_arlen); end
        tick();
        checks++; if (bus.m_axi_arvalid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_after_issue arvalid=%0b busy=%0b exp=0/1", bus.m_axi_arvalid, busy); end
        for (int b = 0; b < 4; b++) begin
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rid    = 4'd2;
            bus.m_axi_rdata  = 32'hA0 + 32'(b);
            bus.m_axi_rlast  = (b == 3);
            bus.req_rready   = 4'b0100;
            #4;
            checks++; if (bus.req_rvalid !== 4'b0100) begin failures++; $display("FAIL single_rvalid beat=%0d got=%b exp=0100", b, bus.req_rvalid); end
            checks++; if (bus.m_axi_rready !== 1'b1 || bus.req_rdata !== 32'hA0 + 32'(b)) begin failures++; $display("FAIL single_rbeat beat=%0d rready=%0b rdata=%0h", b, bus.m_axi_rready, bus.req_rdata); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_burst beat=%0d got=%0b exp=1", b, busy); end
            tick();
        end
        clear_inputs();
        #4;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_done got=%0b exp=0", busy); end
        tick();
    endtask

    task automatic test_round_robin;
        logic [1:0] seq [6];
        seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        for (int i = 0; i < N; i++) begin
            bus.req_araddr[i*AW +: AW] = 32'h100 * 32'(i);
        end
        bus.req_arvalid   = 4'b1111;
        bus.m_axi_arready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #4;
            checks++; if (bus.req_arready !== (4'b0001 << seq[c])) begin failures++; $display("FAIL rr_grant cyc=%0d got=%b exp_idx=%0d", c, bus.req_arready, seq[c]); end
            tick();
            checks++; if (bus.m_axi_arvalid !== 1'b1 || bus.m_axi_arid !== 4'(seq[c]) || bus.m_axi_araddr !== 32'h100 * 32'(seq[c])) begin
                failures++; $display("FAIL rr_arid cyc=%0d arvalid=%0b arid=%0d araddr=%0h exp_id=%0d", c, bus.m_axi_arvalid, bus.m_axi_arid, bus.m_axi_araddr, seq[c]);
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_backpressure;
        do_reset();
        bus.req_araddr[0 +: AW]  = 32'hAAAA_0000;
        bus.req_araddr[AW +: AW] = 32'hBBBB_0000;
        bus.req_arvalid          = 4'b0011;
        #4;
        checks++; if (bus.req_arready !== 4'b0001) begin failures++; $display("FAIL bp_first got=%b exp=0001", bus.req_arready); end
        tick();
        for (int c = 0; c < 5; c++) begin
            #4;
            checks++; if (bus.req_arready !== 4'b0000) begin failures++; $display("FAIL bp_arready cyc=%0d got=%b exp=0000", c, bus.req_arready); end
            tick();
            checks++; if (bus.m_axi_arvalid !== 1'b1 || bus.m_axi_arid !== 4'd0 || bus.m_axi_araddr !== 32'hAAAA_0000) begin
                failures++; $display("FAIL bp_hold cyc=%0d arvalid=%0b arid=%0d araddr=%0h exp=1/0/aaaa0000", c, bus.m_axi_arvalid, bus.m_axi_arid, bus.m_axi_araddr);
            end
        end
`ifdef GLAY_AXI_READ_ARBITER_PERF_EN
        checks++; if (perf_ar_stall_cycles !== 32'd5) begin failures++; $display("FAIL bp_perf got=%0d exp=5", perf_ar_stall_cycles); end
`endif
        bus.m_axi_arready = 1'b1;
        #4;
        checks++; if (bus.req_arready !== 4'b0010) begin failures++; $display("FAIL bp_release got=%b exp=0010", bus.req_arready); end
        tick();
        checks++; if (bus.m_axi_arid !== 4'd1 || bus.m_axi_araddr !== 32'hBBBB_0000) begin failures++; $display("FAIL bp_next arid=%0d araddr=%0h exp=1/bbbb0000", bus.m_axi_arid, bus.m_axi_araddr); end
        clear_inputs();
        tick();
    endtask

    task automatic test_outstanding_cap;
        do_reset();
        bus.req_arvalid   = 4'b0001;
        bus.m_axi_arready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #4;
            checks++; if (bus.req_arready !== 4'b0001) begin failures++; $display("FAIL cap_accept cyc=%0d got=%b exp=0001", c, bus.req_arready); end
            tick();
        end
        #4;
        checks++; if (bus.req_arready !== 4'b0000) begin failures++; $display("FAIL cap_block got=%b exp=0000", bus.req_arready); end
        tick();
        checks++; if (bus.m_axi_arvalid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL cap_idle arvalid=%0b busy=%0b exp=0/1", bus.m_axi_arvalid, busy); end
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rid    = 4'd0;
        bus.m_axi_rlast  = 1'b1;
        bus.req_rready   = 4'b0001;
        #4;
        checks++; if (bus.req_arready !== 4'b0000) begin failures++; $display("FAIL cap_during_rlast got=%b exp=0000", bus.req_arready); end
        tick();
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        #4;
        checks++; if (bus.req_arready !== 4'b0001) begin failures++; $display("FAIL cap_reenable got=%b exp=0001", bus.req_arready); end
        tick();
        #4;
        checks++; if (bus.req_arready !== 4'b0000) begin failures++; $display("FAIL cap_reblock got=%b exp=0000", bus.req_arready); end
        clear_inputs();
        tick();
    endtask

    task automatic test_simultaneous_and_error;
        do_reset();
        bus.req_arvalid   = 4'b0010;
        bus.m_axi_arready = 1'b1;
        tick();
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rid    = 4'd1;
        bus.m_axi_rlast  = 1'b1;
        bus.req_rready   = 4'b0010;
        #4;
        checks++; if (bus.req_arready !== 4'b0010 || bus.req_rvalid !== 4'b0010) begin failures++; $display("FAIL sim_both arready=%b rvalid=%b exp=0010/0010", bus.req_arready, bus.req_rvalid); end
        tick();
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        #4;
        checks++; if (bus.req_arready !== 4'b0010) begin failures++; $display("FAIL sim_count_one got=%b exp=0010", bus.req_arready); end
        tick();
        #4;
        checks++; if (bus.req_arready !== 4'b0000) begin failures++; $display("FAIL sim_count_two got=%b exp=0000", bus.req_arready); end
        bus.req_arvalid  = 4'b0000;
        bus.req_rready   = 4'b0000;
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rid    = 4'd7;
        bus.m_axi_rlast  = 1'b1;
        #1;
        checks++; if (bus.m_axi_rready !== 1'b1 || bus.req_rvalid !== 4'b0000) begin failures++; $display("FAIL err_drain rready=%0b rvalid=%b exp=1/0000", bus.m_axi_rready, bus.req_rvalid); end
        checks++; if (rid_error !== 1'b0) begin failures++; $display("FAIL err_before got=%0b exp=0", rid_error); end
        tick();
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        tick();
        checks++; if (rid_error !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b exp=1", rid_error); end
    endtask

    task automatic test_reset_mid_operation;
        bus.req_arvalid   = 4'b0001;
        bus.m_axi_arready = 1'b0;
        tick();
        checks++; if (bus.m_axi_arvalid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rst_mid_setup arvalid=%0b busy=%0b exp=1/1", bus.m_axi_arvalid, busy); end
        ap_rst_n = 1'b0;
        #1;
        checks++; if (bus.m_axi_arvalid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_async arvalid=%0b busy=%0b exp=0/0", bus.m_axi_arvalid, busy); end
        checks++; if (rid_error !== 1'b0) begin failures++; $display("FAIL rst_mid_err got=%0b exp=0", rid_error); end
        #2;
        ap_rst_n          = 1'b1;
        bus.req_arvalid   = 4'b1111;
        bus.m_axi_arready = 1'b1;
        #1;
        checks++; if (bus.req_arready !== 4'b0001) begin failures++; $display("FAIL rst_mid_first_grant got=%b exp=0001", bus.req_arready); end
        tick();
        checks++; if (bus.m_axi_arvalid !== 1'b1 || bus.m_axi_arid !== 4'd0) begin failures++; $display("FAIL rst_mid_issue arvalid=%0b arid=%0d exp=1/0", bus.m_axi_arvalid, bus.m_axi_arid); end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_round_robin();
        test_backpressure();
        test_outstanding_cap();
        test_simultaneous_and_error();
        test_reset_mid_operation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
